// File: rtl/rca_pkg.sv
// Shared constants for the ripple-carry adder slice.
package rca_pkg;

    localparam int unsigned RCA_DEFAULT_N = 64;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; one link of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/rca_parametrizable.sv
// N-bit ripple-carry adder with combinational sum/carry/overflow and a registered copy
// of each, cleared asynchronously by rst_n.
module rca_parametrizable
    import rca_pkg::*;
#(
    parameter int unsigned N = RCA_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf,
    output logic [N-1:0] Sum_q,
    output logic         Cout_q,
    output logic         Ovf_q
);

    // c[i] is the carry into bit i; c[N] is the carry out of the MSB.
    logic [N:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (Sum[i]),
            .cout (c[i+1])
        );
    end

    assign Cout = c[N];
    // For N=1, c[N-1] is c[0], which is Cin.
    assign Ovf  = c[N] ^ c[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum_q  <= '0;
            Cout_q <= 1'b0;
            Ovf_q  <= 1'b0;
        end else begin
            Sum_q  <= Sum;
            Cout_q <= Cout;
            Ovf_q  <= Ovf;
        end
    end

endmodule

// File: tb/tb_rca_parametrizable.sv
// Directed self-checking bench for rca_parametrizable at N=64, 100 ns clock.
module tb_rca_parametrizable;

    localparam int unsigned N = 64;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic [N-1:0] Sum_q;
    logic         Cout_q;
    logic         Ovf_q;

    int checks;
    int errors;

    rca_parametrizable #(
        .N (N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Sum    (Sum),
        .Cout   (Cout),
        .Ovf    (Ovf),
        .Sum_q  (Sum_q),
        .Cout_q (Cout_q),
        .Ovf_q  (Ovf_q)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Reference: 65-bit sum plus overflow from the operand/result sign bits.
    function automatic logic [N+1:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic ci);
        logic [N:0] r;
        logic       ov;
        r  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
        ov = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
        return {ov, r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        A     = 64'h0;
        B     = 64'h0;
        Cin   = 1'b0;
        #1;
        checks++;
        if (Sum_q !== 64'h0) begin
            errors++;
            $display("FAIL reset_sum_q got %h want 0", Sum_q);
        end
        checks++;
        if (Cout_q !== 1'b0 || Ovf_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags_q got cout_q=%b ovf_q=%b want 0 0", Cout_q, Ovf_q);
        end
        // REQ-029 vector, observed while reset is held.
        checks++;
        if (Sum !== 64'h0 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL zero_vector got sum=%h cout=%b ovf=%b want 0 0 0", Sum, Cout, Ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [N-1:0] va   [4];
        logic [N-1:0] vb   [4];
        logic         vc   [4];
        logic [N-1:0] esum [4];
        logic         ecout[4];
        logic         eovf [4];
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h0; vc[0] = 1'b1;
        esum[0] = 64'h0; ecout[0] = 1'b1; eovf[0] = 1'b0;
        va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'h1; vc[1] = 1'b0;
        esum[1] = 64'h8000_0000_0000_0000; ecout[1] = 1'b0; eovf[1] = 1'b1;
        va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000; vc[2] = 1'b0;
        esum[2] = 64'h0; ecout[2] = 1'b1; eovf[2] = 1'b1;
        va[3] = 64'h1234_5678_9ABC_DEF0; vb[3] = 64'h0FED_CBA9_8765_4321; vc[3] = 1'b1;
        esum[3] = 64'h2222_2222_2222_2212; ecout[3] = 1'b0; eovf[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A   = va[i];
            B   = vb[i];
            Cin = vc[i];
            #1;
            checks++;
            if (Sum !== esum[i]) begin
                errors++;
                $display("FAIL vec%0d_sum got %h want %h", i, Sum, esum[i]);
            end
            checks++;
            if (Cout !== ecout[i] || Ovf !== eovf[i]) begin
                errors++;
                $display("FAIL vec%0d_flags got cout=%b ovf=%b want %b %b", i, Cout, Ovf,
                         ecout[i], eovf[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (Sum_q !== esum[i] || Cout_q !== ecout[i] || Ovf_q !== eovf[i]) begin
                errors++;
                $display("FAIL vec%0d_reg got %h %b %b want %h %b %b", i, Sum_q, Cout_q, Ovf_q,
                         esum[i], ecout[i], eovf[i]);
            end
        end
    endtask

    task automatic test_hold_edge();
        @(negedge clk);
        A   = 64'd5;
        B   = 64'd3;
        Cin = 1'b1;
        #1;
        checks++;
        if (Sum !== 64'd9) begin
            errors++;
            $display("FAIL hold_sum_comb got %h want 9", Sum);
        end
        checks++;
        if (Sum_q === 64'd9) begin
            errors++;
            $display("FAIL hold_sum_q_early got %h want previous value before edge", Sum_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Sum_q !== 64'd9 || Cout_q !== 1'b0 || Ovf_q !== 1'b0) begin
            errors++;
            $display("FAIL hold_sum_q got %h %b %b want 9 0 0", Sum_q, Cout_q, Ovf_q);
        end
    endtask

    task automatic test_midreset();
        // Sum_q=9 loaded by test_hold_edge; pulse reset between edges.
        #10;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Sum_q !== 64'h0 || Cout_q !== 1'b0 || Ovf_q !== 1'b0) begin
            errors++;
            $display("FAIL midreset_q got %h %b %b want 0 0 0", Sum_q, Cout_q, Ovf_q);
        end
        checks++;
        if (Sum !== 64'd9) begin
            errors++;
            $display("FAIL midreset_sum got %h want 9", Sum);
        end
        #5;
        rst_n = 1'b1;
        #1;
        checks++;
        if (Sum_q !== 64'h0) begin
            errors++;
            $display("FAIL post_reset_no_edge got %h want 0", Sum_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (Sum_q !== 64'd9) begin
            errors++;
            $display("FAIL post_reset_first_edge got %h want 9", Sum_q);
        end
        // Reset again with every registered bit set, to see all three clear.
        @(negedge clk);
        A   = 64'h8000_0000_0000_0000;
        B   = 64'h8000_0000_0000_0001;
        Cin = 1'b0;
        @(posedge clk);
        #10;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Sum_q !== 64'h0 || Cout_q !== 1'b0 || Ovf_q !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags got %h %b %b want 0 0 0", Sum_q, Cout_q, Ovf_q);
        end
        checks++;
        if (Sum !== 64'h1 || Cout !== 1'b1 || Ovf !== 1'b1) begin
            errors++;
            $display("FAIL midreset_comb got %h %b %b want 1 1 1", Sum, Cout, Ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [N+1:0] exp_now;
        logic [N+1:0] latched;
        bit           have_latched;
        have_latched = 1'b0;
        latched      = '0;
        @(negedge clk);
        #5;
        // Changes land at negedge+5+10k; the one at +45 is what the edge at +50 captures.
        for (int i = 0; i < 30; i++) begin
            A   = {$urandom, $urandom};
            B   = {$urandom, $urandom};
            Cin = 1'($urandom_range(1));
            exp_now = ref_add(A, B, Cin);
            #1;
            checks++;
            if ({Ovf, Cout, Sum} !== exp_now) begin
                errors++;
                $display("FAIL stream%0d_comb got %b %b %h want %b %b %h", i, Ovf, Cout, Sum,
                         exp_now[N+1], exp_now[N], exp_now[N-1:0]);
            end
            if (have_latched && (i % 10) != 4) begin
                checks++;
                if ({Ovf_q, Cout_q, Sum_q} !== latched) begin
                    errors++;
                    $display("FAIL stream%0d_reg got %b %b %h want %b %b %h", i, Ovf_q, Cout_q,
                             Sum_q, latched[N+1], latched[N], latched[N-1:0]);
                end
            end
            if ((i % 10) == 4) begin
                #9;
                // Crosses the rising edge; registered outputs now hold this step's result.
                latched      = exp_now;
                have_latched = 1'b1;
                checks++;
                if ({Ovf_q, Cout_q, Sum_q} !== latched) begin
                    errors++;
                    $display("FAIL stream%0d_edge got %b %b %h want %b %b %h", i, Ovf_q, Cout_q,
                             Sum_q, latched[N+1], latched[N], latched[N-1:0]);
                end
            end else begin
                #9;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vectors();
        test_hold_edge();
        test_midreset();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
